// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous dmem port between a processor and a loader.
// Fixed priority with a loader starvation guard by default; define DMEM_ARB_RR_EN for round-robin.

module dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  // processor port
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_q,
  // loader port
  input  logic              l_req,
  input  logic              l_wren,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_data,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_q,
  // shared dmem port
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN_P,
    OWN_L
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  burst_cnt, burst_next;
  logic              win_p, win_l;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_data;
  logic              mux_wren;
  logic              p_rd_pend, l_rd_pend;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    win_p      = 1'b0;
    win_l      = 1'b0;
    state_next = IDLE;
    burst_next = '0;
    mux_addr   = '0;
    mux_data   = '0;
    mux_wren   = 1'b0;

    if (p_req && l_req) begin
`ifdef DMEM_ARB_RR_EN
      // Whoever was not served last wins; IDLE falls through to the processor.
      if (state == OWN_P) win_l = 1'b1;
      else                win_p = 1'b1;
`else
      if (burst_cnt == CNT_W'(MAX_BURST)) win_l = 1'b1;
      else                                win_p = 1'b1;
`endif
    end else if (p_req) begin
      win_p = 1'b1;
    end else if (l_req) begin
      win_l = 1'b1;
    end

    if (win_p) begin
      state_next = OWN_P;
      mux_addr   = p_addr;
      mux_data   = p_data;
      mux_wren   = p_wren;
    end else if (win_l) begin
      state_next = OWN_L;
      mux_addr   = l_addr;
      mux_data   = l_data;
      mux_wren   = l_wren;
    end

    // Counts processor grants only while the loader is kept waiting.
    if (win_p && l_req) burst_next = burst_cnt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state        <= IDLE;
      burst_cnt    <= '0;
      p_gnt        <= 1'b0;
      l_gnt        <= 1'b0;
      p_rd_pend    <= 1'b0;
      l_rd_pend    <= 1'b0;
      address_dmem <= '0;
      data         <= '0;
      wren         <= 1'b0;
    end else begin
      state        <= state_next;
      burst_cnt    <= burst_next;
      p_gnt        <= win_p;
      l_gnt        <= win_l;
      p_rd_pend    <= p_gnt & ~wren;
      l_rd_pend    <= l_gnt & ~wren;
      address_dmem <= mux_addr;
      data         <= mux_data;
      wren         <= mux_wren;
    end
  end

  // dmem answers one cycle after the grant cycle, which is exactly the pending-read cycle.
  assign p_rvalid = p_rd_pend;
  assign l_rvalid = l_rd_pend;
  assign p_q      = p_rd_pend ? q_dmem : '0;
  assign l_q      = l_rd_pend ? q_dmem : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural arbitration/memory model predicts grants and read data.
// Build with DMEM_ARB_RR_EN defined to check the round-robin variant.

module tb_dmem_arbiter;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } acc_t;

  typedef struct {
    int   cyc;
    bit   is_l;
    acc_t a;
  } gexp_t;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] d;
  } rexp_t;

  logic              clock  = 1'b0;
  logic              reset  = 1'b1;
  logic              p_req  = 1'b0, p_wren = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [DATA_W-1:0] p_data = '0;
  logic              l_req  = 1'b0, l_wren = 1'b0;
  logic [ADDR_W-1:0] l_addr = '0;
  logic [DATA_W-1:0] l_data = '0;
  logic              p_gnt, p_rvalid, l_gnt, l_rvalid, wren;
  logic [DATA_W-1:0] p_q, l_q, data;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] q_dmem = '0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_q(p_q),
    .l_req(l_req), .l_wren(l_wren), .l_addr(l_addr), .l_data(l_data),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_q(l_q),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  // dmem with a backdoor write port used only for preloading
  logic              bd_we   = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;
  logic [DATA_W-1:0] dmem [DEPTH];

  always @(posedge clock) begin
    if (bd_we)     dmem[bd_addr] <= bd_data;
    else if (wren) dmem[address_dmem] <= data;
    q_dmem <= dmem[address_dmem];
  end

  acc_t              p_stim[$], l_stim[$];
  gexp_t             g_exp[$];
  rexp_t             p_rexp[$], l_rexp[$];
  logic [DATA_W-1:0] ref_mem [int];
  int                cyc = 0;
  int                n_cmp = 0, n_bad = 0;
  bit                drop_en = 1'b0;
  bit                gnt_log[$];
  int                gnt_cyc_log[$];
  logic [DATA_W-1:0] p_rd_log[$], l_rd_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decides the winner from the requests seen at each edge.
  int   streak = 0;
  int   last_win = 0;   // 0 none, 1 processor, 2 loader
  int   m_win;
  bit   prev_v = 1'b0, prev_l = 1'b0;
  acc_t prev_a;

  always @(posedge clock) begin
    cyc++;
    if (prev_v) begin
      if (prev_a.wr) ref_mem[int'(prev_a.addr)] = prev_a.dat;
      else if (!reset) begin
        if (prev_l) l_rexp.push_back(rexp_t'{cyc, ref_mem[int'(prev_a.addr)]});
        else        p_rexp.push_back(rexp_t'{cyc, ref_mem[int'(prev_a.addr)]});
      end
    end
    prev_v = 1'b0;
    m_win  = 0;
    if (reset) begin
      streak   = 0;
      last_win = 0;
    end else begin
      if (p_req && l_req) begin
`ifdef DMEM_ARB_RR_EN
        m_win = (last_win == 1) ? 2 : 1;
`else
        m_win = (streak >= MAX_BURST) ? 2 : 1;
`endif
      end else if (p_req) m_win = 1;
      else if (l_req)     m_win = 2;
      streak   = (m_win == 1 && l_req) ? streak + 1 : 0;
      last_win = m_win;
      if (m_win != 0) begin
        prev_l = (m_win == 2);
        prev_a = prev_l ? acc_t'{l_wren, l_addr, l_data} : acc_t'{p_wren, p_addr, p_data};
        prev_v = 1'b1;
        g_exp.push_back(gexp_t'{cyc, prev_l, prev_a});
      end
    end
  end

  // Requesters: retire the head access on gnt, then present the next one (or idle / back off).
  always @(negedge clock) begin
    if (p_gnt && p_stim.size() > 0) void'(p_stim.pop_front());
    if (l_gnt && l_stim.size() > 0) void'(l_stim.pop_front());
    if (p_stim.size() > 0 && !(drop_en && $urandom_range(0, 7) == 0)) begin
      p_req = 1'b1; p_wren = p_stim[0].wr; p_addr = p_stim[0].addr; p_data = p_stim[0].dat;
    end else begin
      p_req = 1'b0; p_wren = 1'b0; p_addr = '0; p_data = '0;
    end
    if (l_stim.size() > 0 && !(drop_en && $urandom_range(0, 7) == 0)) begin
      l_req = 1'b1; l_wren = l_stim[0].wr; l_addr = l_stim[0].addr; l_data = l_stim[0].dat;
    end else begin
      l_req = 1'b0; l_wren = 1'b0; l_addr = '0; l_data = '0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or read data.
  gexp_t ge;
  rexp_t re;

  always @(negedge clock) begin
    if (p_gnt || l_gnt) begin
      check("gnt_exclusive", 64'(p_gnt & l_gnt), 64'(0));
      check("gnt_expected", 64'(g_exp.size() > 0), 64'(1));
      if (g_exp.size() > 0) begin
        ge = g_exp.pop_front();
        check("gnt_cycle", 64'(cyc), 64'(ge.cyc));
        check("gnt_port_is_l", 64'(l_gnt), 64'(ge.is_l));
        check("gnt_addr", 64'(address_dmem), 64'(ge.a.addr));
        check("gnt_data", 64'(data), 64'(ge.a.dat));
        check("gnt_wren", 64'(wren), 64'(ge.a.wr));
      end
      gnt_log.push_back(l_gnt);
      gnt_cyc_log.push_back(cyc);
    end else begin
      check("idle_bus", 64'({address_dmem, data, wren}), 64'(0));
      if (g_exp.size() > 0) begin
        check("gnt_missing", 64'(g_exp[0].cyc > cyc), 64'(1));
        if (g_exp[0].cyc <= cyc) void'(g_exp.pop_front());
      end
    end

    if (p_rvalid) begin
      check("p_rd_expected", 64'(p_rexp.size() > 0), 64'(1));
      if (p_rexp.size() > 0) begin
        re = p_rexp.pop_front();
        check("p_rd_cycle", 64'(cyc), 64'(re.cyc));
        check("p_q", 64'(p_q), 64'(re.d));
      end
      p_rd_log.push_back(p_q);
    end else begin
      check("p_q_idle", 64'(p_q), 64'(0));
      if (p_rexp.size() > 0) begin
        check("p_rd_missing", 64'(p_rexp[0].cyc > cyc), 64'(1));
        if (p_rexp[0].cyc <= cyc) void'(p_rexp.pop_front());
      end
    end

    if (l_rvalid) begin
      check("l_rd_expected", 64'(l_rexp.size() > 0), 64'(1));
      if (l_rexp.size() > 0) begin
        re = l_rexp.pop_front();
        check("l_rd_cycle", 64'(cyc), 64'(re.cyc));
        check("l_q", 64'(l_q), 64'(re.d));
      end
      l_rd_log.push_back(l_q);
    end else begin
      check("l_q_idle", 64'(l_q), 64'(0));
      if (l_rexp.size() > 0) begin
        check("l_rd_missing", 64'(l_rexp[0].cyc > cyc), 64'(1));
        if (l_rexp[0].cyc <= cyc) void'(l_rexp.pop_front());
      end
    end
  end

  task automatic preload(input int a, input logic [DATA_W-1:0] d);
    bd_we   = 1'b1;
    bd_addr = ADDR_W'(a);
    bd_data = d;
    ref_mem[a] = d;
    @(posedge clock); #1;
    bd_we = 1'b0;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc_log.delete();
    p_rd_log.delete();
    l_rd_log.delete();
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clock); #1;
      done = (p_stim.size() == 0 && l_stim.size() == 0 && g_exp.size() == 0 &&
              p_rexp.size() == 0 && l_rexp.size() == 0 && !prev_v);
    end
    check(tag, 64'(done), 64'(1));
  endtask

  function automatic acc_t rand_acc();
    acc_t a;
    a.wr   = 1'($urandom_range(0, 1));
    a.addr = ADDR_W'($urandom_range(0, 31));
    a.dat  = $urandom;
    return a;
  endfunction

  string pat;

  initial begin
    @(posedge clock); #1;
    for (int a = 0; a < 32; a++) preload(a, (a == 16) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(a));
    preload(255, 32'h0);

    // outputs while reset is held
    check("rst_ctrl", 64'({p_gnt, l_gnt, p_rvalid, l_rvalid, wren}), 64'(0));
    check("rst_bus", 64'({address_dmem, data}), 64'(0));
    check("rst_q", 64'({p_q, l_q}), 64'(0));
    reset = 1'b0;

    // processor read of a preloaded word
    clear_logs();
    p_stim.push_back(acc_t'{1'b0, 12'h010, 32'h0});
    wait_drain("drain_p_read");
    check("p_read_count", 64'(p_rd_log.size()), 64'(1));
    if (p_rd_log.size() > 0) check("p_read_data", 64'(p_rd_log[0]), 64'(32'hDEADBEEF));

    // loader write then read-back
    clear_logs();
    l_stim.push_back(acc_t'{1'b1, 12'h0FF, 32'h12345678});
    l_stim.push_back(acc_t'{1'b0, 12'h0FF, 32'h0});
    wait_drain("drain_l_wr_rd");
    check("l_grant_count", 64'(gnt_log.size()), 64'(2));
    check("l_rvalid_count", 64'(l_rd_log.size()), 64'(1));
    if (l_rd_log.size() > 0) check("l_readback", 64'(l_rd_log[0]), 64'(32'h12345678));

    // processor back-to-back reads
    clear_logs();
    for (int i = 1; i <= 3; i++) p_stim.push_back(acc_t'{1'b0, ADDR_W'(i), 32'h0});
    wait_drain("drain_b2b");
    check("b2b_grants", 64'(gnt_cyc_log.size()), 64'(3));
    if (gnt_cyc_log.size() == 3) begin
      check("b2b_gap1", 64'(gnt_cyc_log[1] - gnt_cyc_log[0]), 64'(1));
      check("b2b_gap2", 64'(gnt_cyc_log[2] - gnt_cyc_log[1]), 64'(1));
    end
    check("b2b_rd_count", 64'(p_rd_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < p_rd_log.size(); i++)
      check("b2b_rd_data", 64'(p_rd_log[i]), 64'(32'hC0DE0001 + 32'(i)));

    // sustained contention
    clear_logs();
    for (int i = 0; i < 12; i++) begin
      p_stim.push_back(acc_t'{1'b0, ADDR_W'(i), 32'h0});
      l_stim.push_back(acc_t'{1'b0, ADDR_W'(16 + i), 32'h0});
    end
    wait_drain("drain_contention");
`ifdef DMEM_ARB_RR_EN
    pat = "PLPLPLPLPLPL";
`else
    pat = "PPPPLPPPPLPP";
`endif
    check("cont_grants", 64'(gnt_log.size()), 64'(24));
    for (int i = 0; i < 12 && i < gnt_log.size(); i++)
      check("cont_pattern", 64'(gnt_log[i]), 64'(pat[i] == "L"));

    // reset sampled at the end of a read-grant cycle
    clear_logs();
    p_stim.push_back(acc_t'{1'b0, 12'h005, 32'h0});
    p_stim.push_back(acc_t'{1'b0, 12'h006, 32'h0});
    for (int i = 0; i < 20 && !p_gnt; i++) begin
      @(posedge clock); #1;
    end
    check("rst_mid_gnt_seen", 64'(p_gnt), 64'(1));
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_ctrl", 64'({p_gnt, l_gnt, p_rvalid, l_rvalid, wren}), 64'(0));
    check("rst_mid_bus", 64'({address_dmem, data}), 64'(0));
    check("rst_mid_q", 64'({p_q, l_q}), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_resume_gnt", 64'(p_gnt), 64'(1));
    check("rst_resume_addr", 64'(address_dmem), 64'(12'h006));
    wait_drain("drain_reset");
    check("rst_rd_count", 64'(p_rd_log.size()), 64'(1));
    if (p_rd_log.size() > 0) check("rst_rd_data", 64'(p_rd_log[0]), 64'(32'hC0DE0006));

    // randomized traffic with requesters occasionally backing off
    drop_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1;
      if (p_stim.size() < 3 && $urandom_range(0, 2) == 0) p_stim.push_back(rand_acc());
      if (l_stim.size() < 3 && $urandom_range(0, 2) == 0) l_stim.push_back(rand_acc());
    end
    drop_en = 1'b0;
    wait_drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
